// File: rtl/vec_elem_seq_if.sv
// Bundle of the sequencer's control inputs and index/marker outputs.
interface vec_elem_seq_if;
    logic       start;
    logic [2:0] len;
    logic       stall;
    logic       abort;
    logic [2:0] idx;
    logic       idx_sel;
    logic       busy;
    logic       acc_en;
    logic       first;
    logic       last;
    logic       done;

    // Requester side: drives the controls, observes the sequence
    modport master (
        output start, len, stall, abort,
        input  idx, idx_sel, busy, acc_en, first, last, done
    );

    // Sequencer side
    modport slave (
        input  start, len, stall, abort,
        output idx, idx_sel, busy, acc_en, first, last, done
    );
endinterface

// File: rtl/vec_elem_seq.sv
// Element-index sequencer for vector/MAC instructions: walks a 3-bit index
// from 0 to a latched last index, one element per unstalled cycle, and emits
// index-mux control plus accumulate-enable and first/last/done markers.
module vec_elem_seq (
    input  logic          clk,
    input  logic          reset,
    vec_elem_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [2:0] end_idx;

    // State, element counter and latched last index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            cnt     <= 3'd0;
            end_idx <= 3'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.start && !bus.abort) begin
                        cnt     <= 3'd0;
                        end_idx <= bus.len;
                        state   <= StRun;
                    end
                end
                StRun: begin
                    // Abort beats stall beats completion; the terminal test
                    // comes before the increment so the counter never wraps.
                    if (bus.abort) begin
                        cnt   <= 3'd0;
                        state <= StIdle;
                    end else if (bus.stall) begin
                        cnt   <= cnt;
                    end else if (cnt == end_idx) begin
                        state <= StDone;
                    end else begin
                        cnt   <= cnt + 3'd1;
                    end
                end
                StDone: begin
                    cnt   <= 3'd0;
                    state <= StIdle;
                end
                default: begin
                    cnt   <= 3'd0;
                    state <= StIdle;
                end
            endcase
        end
    end

    // Output decode from state, counter, last index and stall
    always_comb begin
        bus.idx     = 3'd0;
        bus.idx_sel = 1'b0;
        bus.busy    = 1'b0;
        bus.acc_en  = 1'b0;
        bus.first   = 1'b0;
        bus.last    = 1'b0;
        bus.done    = 1'b0;
        if (state == StRun) begin
            bus.idx     = cnt;
            bus.idx_sel = 1'b1;
            bus.busy    = 1'b1;
            bus.acc_en  = !bus.stall;
            bus.first   = (cnt == 3'd0);
            bus.last    = (cnt == end_idx);
        end else if (state == StDone) begin
            bus.busy    = 1'b1;
            bus.done    = 1'b1;
        end
    end

endmodule

// File: tb/tb_vec_elem_seq.sv
// Scoreboard bench for vec_elem_seq: the stimulus process queues the expected
// output vector for every busy cycle; a monitor pops and compares whenever
// the DUT reports busy, and checks all-zero outputs otherwise.
module tb_vec_elem_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;

    vec_elem_seq_if bus ();

    vec_elem_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Packed view: {idx[2:0], idx_sel, busy, acc_en, first, last, done}
    logic [8:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         exp_acc = 0;
    int         got_acc = 0;

    localparam logic [8:0] NoExp = 9'd0;

    function automatic logic [8:0] r(input logic [2:0] i, input logic a,
                                     input logic f, input logic l);
        return {i, 1'b1, 1'b1, a, f, l, 1'b0};
    endfunction

    function automatic logic [8:0] d();
        return 9'b000_0_1_0_0_0_1;
    endfunction

    function automatic logic [8:0] outs();
        return {bus.idx, bus.idx_sel, bus.busy, bus.acc_en, bus.first, bus.last, bus.done};
    endfunction

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got idx/sel/busy/acc/first/last/done=%b expected %b at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; optionally queue the outputs expected this cycle
    task automatic cyc(input logic st, input logic [2:0] ln, input logic sl, input logic ab,
                       input logic has, input logic [8:0] e);
        bus.start = st;
        bus.len   = ln;
        bus.stall = sl;
        bus.abort = ab;
        if (has) begin
            exp_q.push_back(e);
            exp_acc += int'(e[3]);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: sample mid-cycle, away from the active edge
    always @(negedge clk) begin
        logic [8:0] got;
        got = outs();
        if (got[3]) got_acc++;
        if (bus.busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_busy: got %b expected idle at %0t", got, $time);
            end else begin
                chk("seq", got, exp_q.pop_front());
            end
        end else begin
            chk("idle", got, NoExp);
            chk_int("pending", exp_q.size(), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.len   = 3'd0;
        bus.stall = 1'b0;
        bus.abort = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(0, 0, 0, 0, 0, NoExp);

        // len=3, no stall; len changes after acceptance must not matter
        cyc(1, 3, 0, 0, 0, NoExp);
        cyc(0, 0, 0, 0, 1, r(0, 1, 1, 0));
        cyc(0, 7, 0, 0, 1, r(1, 1, 0, 0));
        cyc(0, 0, 0, 0, 1, r(2, 1, 0, 0));
        cyc(0, 0, 0, 0, 1, r(3, 1, 0, 1));
        cyc(0, 0, 0, 0, 1, d());
        cyc(0, 0, 1, 0, 0, NoExp);

        // len=0: first and last together
        cyc(1, 0, 0, 0, 0, NoExp);
        cyc(0, 0, 0, 0, 1, r(0, 1, 1, 1));
        cyc(0, 0, 0, 0, 1, d());
        cyc(0, 0, 0, 0, 0, NoExp);

        // len=7, stall 2 cycles at idx 2 and 1 cycle at idx 7; stall in DONE inert
        cyc(1, 7, 0, 0, 0, NoExp);
        cyc(0, 0, 0, 0, 1, r(0, 1, 1, 0));
        cyc(0, 0, 0, 0, 1, r(1, 1, 0, 0));
        cyc(0, 0, 1, 0, 1, r(2, 0, 0, 0));
        cyc(0, 0, 1, 0, 1, r(2, 0, 0, 0));
        cyc(0, 0, 0, 0, 1, r(2, 1, 0, 0));
        cyc(0, 0, 0, 0, 1, r(3, 1, 0, 0));
        cyc(0, 0, 0, 0, 1, r(4, 1, 0, 0));
        cyc(0, 0, 0, 0, 1, r(5, 1, 0, 0));
        cyc(0, 0, 0, 0, 1, r(6, 1, 0, 0));
        cyc(0, 0, 1, 0, 1, r(7, 0, 0, 1));
        cyc(0, 0, 0, 0, 1, r(7, 1, 0, 1));
        cyc(0, 0, 1, 0, 1, d());
        cyc(0, 0, 0, 0, 0, NoExp);

        // len=5 with start held through RUN and DONE: no second sequence
        cyc(1, 5, 0, 0, 0, NoExp);
        cyc(1, 2, 0, 0, 1, r(0, 1, 1, 0));
        cyc(1, 2, 0, 0, 1, r(1, 1, 0, 0));
        cyc(1, 2, 0, 0, 1, r(2, 1, 0, 0));
        cyc(1, 2, 0, 0, 1, r(3, 1, 0, 0));
        cyc(1, 2, 0, 0, 1, r(4, 1, 0, 0));
        cyc(1, 2, 0, 0, 1, r(5, 1, 0, 1));
        cyc(1, 2, 0, 0, 1, d());
        cyc(0, 0, 0, 0, 0, NoExp);
        cyc(0, 0, 0, 0, 0, NoExp);
        // len=1, then start in the first IDLE cycle after DONE (len=0)
        cyc(1, 1, 0, 0, 0, NoExp);
        cyc(0, 0, 0, 0, 1, r(0, 1, 1, 0));
        cyc(0, 0, 0, 0, 1, r(1, 1, 0, 1));
        cyc(0, 0, 0, 0, 1, d());
        cyc(1, 0, 0, 0, 0, NoExp);
        cyc(0, 0, 0, 0, 1, r(0, 1, 1, 1));
        cyc(0, 0, 0, 0, 1, d());
        cyc(0, 0, 0, 0, 0, NoExp);

        // len=6 aborted at idx 4; start in the following IDLE cycle is taken
        cyc(1, 6, 0, 0, 0, NoExp);
        cyc(0, 0, 0, 0, 1, r(0, 1, 1, 0));
        cyc(0, 0, 0, 0, 1, r(1, 1, 0, 0));
        cyc(0, 0, 0, 0, 1, r(2, 1, 0, 0));
        cyc(0, 0, 0, 0, 1, r(3, 1, 0, 0));
        cyc(0, 0, 0, 1, 1, r(4, 1, 0, 0));
        cyc(1, 2, 0, 0, 0, NoExp);
        // abort together with stall
        cyc(0, 0, 1, 1, 1, r(0, 0, 1, 0));
        cyc(0, 0, 0, 0, 0, NoExp);
        // start with abort in IDLE is refused
        cyc(1, 3, 0, 1, 0, NoExp);
        cyc(0, 0, 0, 0, 0, NoExp);
        // abort in DONE is ignored
        cyc(1, 0, 0, 0, 0, NoExp);
        cyc(0, 0, 0, 0, 1, r(0, 1, 1, 1));
        cyc(0, 0, 0, 1, 1, d());
        cyc(0, 0, 0, 0, 0, NoExp);

        // Async reset in the middle of the idx 2 cycle
        cyc(1, 4, 0, 0, 0, NoExp);
        cyc(0, 0, 0, 0, 1, r(0, 1, 1, 0));
        cyc(0, 0, 0, 0, 1, r(1, 1, 0, 0));
        exp_q.push_back(r(2, 1, 0, 0));
        exp_acc++;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset", outs(), NoExp);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(0, 0, 0, 0, 0, NoExp);
        // Fresh sequence after reset release
        cyc(1, 2, 0, 0, 0, NoExp);
        cyc(0, 0, 0, 0, 1, r(0, 1, 1, 0));
        cyc(0, 0, 0, 0, 1, r(1, 1, 0, 0));
        cyc(0, 0, 0, 0, 1, r(2, 1, 0, 1));
        cyc(0, 0, 0, 0, 1, d());
        cyc(0, 0, 0, 0, 0, NoExp);
        cyc(0, 0, 0, 0, 0, NoExp);

        @(negedge clk);
        #1;
        chk_int("queue_drained", exp_q.size(), 0);
        chk_int("acc_en_total", got_acc, exp_acc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vec_elem_seq.md
# vec_elem_seq

Element-index sequencer for the extended DLX vector/MAC instructions. On a start request it walks a 3-bit element index from 0 up to a programmed last index, one element per unstalled cycle. It feeds the 3-bit index select mux directly downstream: `idx` drives the mux A input, `idx_sel` drives its select. It also emits accumulate-enable and first/last/done markers for the MAC datapath.

## Interface
- No parameters. Index width is fixed at 3 bits, so at most 8 elements.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; forces IDLE and all outputs low/zero.
- `start` input 1: request a new sequence; sampled only in IDLE.
- `len` input 3: last element index (element count minus 1); sampled with an accepted `start`.
- `stall` input 1: pipeline stall; freezes the index and suppresses `acc_en`.
- `abort` input 1: synchronous cancel; returns to IDLE with no `done`.
- `idx` output 3: current element index; 0 when not in RUN.
- `idx_sel` output 1: 1 while the sequencer owns the index mux (RUN); 0 otherwise.
- `busy` output 1: 1 in RUN or DONE.
- `acc_en` output 1: RUN & !stall; qualifies one MAC step.
- `first` output 1: RUN & idx==0.
- `last` output 1: RUN & idx==end (the latched `len`).
- `done` output 1: one-cycle pulse in DONE.

## Operation
- State register: IDLE, RUN, DONE. Registers: `cnt[2:0]` and `end[2:0]`.
- IDLE:
  - On `start`=1 (and `abort`=0): `cnt`<=0, `end`<=`len`, next state RUN.
  - Otherwise stay in IDLE.
- RUN:
  - `abort`=1 → IDLE; `cnt` cleared. Abort has priority over stall and completion.
  - Else `stall`=1 → hold state and `cnt`.
  - Else `cnt`==`end` → DONE, `cnt` held.
  - Else `cnt`<=`cnt`+1.
- DONE: `done`=1 for exactly one cycle, then unconditionally IDLE; `cnt` cleared. `abort` in DONE is ignored, and `done` still pulses.
- `start` in RUN or DONE is ignored and not queued. `len` is only sampled at acceptance; later changes have no effect.
- Output decode:
  - `idx`=`cnt` in RUN, else 0.
  - `first`, `last` and `acc_en` are combinational from state, `cnt`, `end` and `stall`.
  - `first` and `last` may both be 1 when `len`=0.
- The counter never wraps: the max `end` is 7, and the terminal test precedes the increment.
- Async `reset` mid-sequence: immediate IDLE, `cnt`=`end`=0, all outputs 0, no `done`.

## Timing
- Reset values: `idx`=0, `idx_sel`=0, `busy`=0, `acc_en`=0, `first`=0, `last`=0, `done`=0.
- `start` accepted at edge k → RUN from cycle k+1 with `idx`=0.
- Unstalled sequence: `len`+1 RUN cycles (idx 0..len), then 1 DONE cycle. The earliest next `start` is accepted at the edge leaving DONE+1, i.e. while back in IDLE.
- Stalls:
  - Each stalled RUN cycle adds one cycle.
  - `acc_en` counts exactly `len`+1 pulses per completed sequence, regardless of stalls.
- `abort` sampled at edge m in RUN → IDLE at m+1 (`busy`=0, `idx_sel`=0). A `start` in that same IDLE cycle is accepted normally.
- `stall` in IDLE or DONE has no effect.

## Test plan
- Reset, then `start` with `len`=3, no stall → `idx` 0,1,2,3 on four consecutive cycles with `acc_en`=1. `first` only at idx 0, `last` only at idx 3. `done` pulses the next cycle. `busy` is high for 5 cycles.
- `len`=0 → single RUN cycle with `first`=`last`=`acc_en`=1 and `idx`=0, then `done`.
- `len`=7 with `stall` high at idx 2 (2 cycles) and idx 7 (1 cycle):
  - `idx` holds 2 for 3 cycles and 7 for 2 cycles.
  - `acc_en` totals 8 pulses; RUN lasts 11 cycles.
- `start` re-asserted during RUN and DONE (with `len`=5) → ignored; no second sequence. `start` one cycle after DONE → new sequence from idx 0.
- `abort` at idx 4 of a `len`=6 run → IDLE next cycle, no `done`, `idx_sel`=0. `abort` together with `stall` → still IDLE next cycle.
- Async `reset` pulse mid-cycle at idx 2 → all outputs 0 immediately, before the next edge. After release, a fresh `start` runs correctly.
